// File: rtl/axis_fifo.sv
// Single-clock AXI4-Stream FIFO with first-word-fall-through output.
// Buffers capture samples toward the DMA engine. master_tlast marks every
// packet_len-th word read out. Occupancy is exported as level.
module axis_fifo #(
    parameter int unsigned dataw      = 32,
    parameter int unsigned depth      = 512,
    parameter int unsigned packet_len = 128
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [dataw-1:0]         slave_tdata,
    input  logic                     slave_tvalid,
    output logic                     slave_tready,
    output logic [dataw-1:0]         master_tdata,
    output logic                     master_tvalid,
    output logic                     master_tlast,
    input  logic                     master_tready,
    output logic [$clog2(depth):0]   level
);

    localparam int unsigned AddrW = $clog2(depth);
    localparam int unsigned PtrW  = AddrW + 1;

    // Pointers carry one extra wrap bit so full and empty can be told apart
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [PtrW-1:0]  r_level;
    logic [dataw-1:0] r_mem [depth];

    logic [AddrW-1:0] w_wr_addr;
    logic [AddrW-1:0] w_rd_addr;
    logic             w_empty;
    logic             w_full;
    logic             w_wr_beat;
    logic             w_rd_beat;

    // Status flags and handshake qualification
    always_comb begin
        w_wr_addr = r_wr_ptr[AddrW-1:0];
        w_rd_addr = r_rd_ptr[AddrW-1:0];
        w_empty   = (r_wr_ptr == r_rd_ptr);
        w_full    = (w_wr_addr == w_rd_addr) && (r_wr_ptr[AddrW] != r_rd_ptr[AddrW]);
        w_wr_beat = slave_tvalid & ~w_full;
        w_rd_beat = master_tready & ~w_empty;
    end

    // Outputs are driven purely from registers and the storage array
    always_comb begin
        slave_tready  = ~w_full;
        master_tvalid = ~w_empty;
        master_tdata  = r_mem[w_rd_addr];
        level         = r_level;
    end

    // Storage array; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (w_wr_beat) begin
            r_mem[w_wr_addr] <= slave_tdata;
        end
    end

    // Write and read pointers, both wrapping naturally at 2*depth
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_beat) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_rd_beat) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
        end
    end

    // Occupancy: unchanged when a write and a read land in the same cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_level <= '0;
        end else begin
            unique case ({w_wr_beat, w_rd_beat})
                2'b10:   r_level <= r_level + PtrW'(1);
                2'b01:   r_level <= r_level - PtrW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Packet framing: beat counter tracks read beats, not occupancy, so tlast
    // stays stable while the downstream stalls on the last word
    if (packet_len == 0) begin : g_no_tlast
        always_comb begin
            master_tlast = 1'b0;
        end
    end else begin : g_tlast
        localparam int unsigned CntW = (packet_len > 1) ? $clog2(packet_len) + 1 : 1;
        localparam logic [CntW-1:0] LastCnt = CntW'(packet_len - 1);

        logic [CntW-1:0] r_beat_cnt;
        logic            w_at_last;

        // Last-beat decode gated by head validity
        always_comb begin
            w_at_last    = (r_beat_cnt == LastCnt);
            master_tlast = ~w_empty & w_at_last;
        end

        // Advance on each read beat, wrapping after the tlast beat
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_beat_cnt <= '0;
            end else if (w_rd_beat) begin
                if (w_at_last) begin
                    r_beat_cnt <= '0;
                end else begin
                    r_beat_cnt <= r_beat_cnt + CntW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_fifo.sv
// Self-checking bench for axis_fifo: directed phases plus randomized
// handshakes, all compared against a queue-based reference model.
module tb_axis_fifo;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 512;
    localparam int unsigned PKT   = 128;

    logic          clk;
    logic          reset;
    logic [DW-1:0] slave_tdata;
    logic          slave_tvalid;
    logic          slave_tready;
    logic [DW-1:0] master_tdata;
    logic          master_tvalid;
    logic          master_tlast;
    logic          master_tready;
    logic [9:0]    level;

    axis_fifo #(
        .dataw      (DW),
        .depth      (DEPTH),
        .packet_len (PKT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .slave_tdata   (slave_tdata),
        .slave_tvalid  (slave_tvalid),
        .slave_tready  (slave_tready),
        .master_tdata  (master_tdata),
        .master_tvalid (master_tvalid),
        .master_tlast  (master_tlast),
        .master_tready (master_tready),
        .level         (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: contents in order, and total read beats since reset
    logic [DW-1:0] q[$];
    int            rd_cnt;
    int            checks;
    int            failures;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check outputs, update model at posedge
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r,
                        output logic acc);
        logic wr;
        logic rd;
        @(negedge clk);
        slave_tvalid  = v;
        slave_tdata   = d;
        master_tready = r;
        chk("tready", slave_tready, q.size() < DEPTH);
        chk("tvalid", master_tvalid, q.size() != 0);
        chk("level", level, q.size());
        chk("tlast", master_tlast, (q.size() != 0) && (rd_cnt % PKT == PKT - 1));
        if (q.size() != 0) chk("tdata", master_tdata, q[0]);
        wr  = v && (q.size() < DEPTH);
        rd  = r && (q.size() != 0);
        acc = wr;
        @(posedge clk);
        if (rd) begin
            void'(q.pop_front());
            rd_cnt++;
        end
        if (wr) q.push_back(d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset         = 1'b0;
        slave_tvalid  = 1'b0;
        master_tready = 1'b0;
        q.delete();
        rd_cnt = 0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic acc;
        int   w;
        int   hold;
        int   pw;
        int   pr;
        checks        = 0;
        failures      = 0;
        rd_cnt        = 0;
        reset         = 1'b0;
        slave_tvalid  = 1'b0;
        slave_tdata   = '0;
        master_tready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_tready", slave_tready, 1);
        chk("rst_tvalid", master_tvalid, 0);
        chk("rst_tlast", master_tlast, 0);
        chk("rst_level", level, 0);
        reset = 1'b1;

        // FWFT latency: word written at edge N is visible right after edge N
        step(1'b1, 32'hDEADBEEF, 1'b0, acc);
        #1;
        chk("lat_valid", master_tvalid, 1);
        chk("lat_data", master_tdata, 32'hDEADBEEF);
        step(1'b0, '0, 1'b1, acc);

        // Fill to full with no reads, then try extra writes
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i), 1'b0, acc);
        #1;
        chk("full_level", level, DEPTH);
        chk("full_tready", slave_tready, 0);
        for (int i = 0; i < 5; i++) step(1'b1, 32'hFFFF0000 + DW'(i), 1'b0, acc);
        chk("full_level_hold", level, DEPTH);
        // Drain: model checks order 0..511 and tlast positions
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, acc);
        #1;
        chk("drain_empty", master_tvalid, 0);

        // Streaming: one in, one out each cycle
        do_reset();
        for (int i = 0; i < 60; i++) begin
            step(1'b1, DW'(i), 1'b1, acc);
            #1;
            chk("stream_level", level <= 1, 1);
            chk("stream_valid", master_tvalid, 1);
            chk("stream_data", master_tdata, DW'(i));
        end

        // Packetization with a stall on the tlast word
        do_reset();
        w    = 0;
        hold = 0;
        for (int n = 0; n < 1000 && rd_cnt < 300; n++) begin
            #1;
            if (rd_cnt == PKT - 1 && q.size() != 0 && hold < 3) begin
                chk("pkt_hold_last", master_tlast, 1);
                chk("pkt_hold_data", master_tdata, PKT - 1);
                hold++;
                step(w < 300, DW'(w), 1'b0, acc);
            end else begin
                step(w < 300, DW'(w), 1'b1, acc);
            end
            if (acc) w++;
        end
        chk("pkt_reads", rd_cnt, 300);
        chk("pkt_held", hold, 3);

        // Reset mid-stream with 10 words stored
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 32'h100 + DW'(i), 1'b0, acc);
        @(negedge clk);
        slave_tvalid  = 1'b1;
        slave_tdata   = 32'hBAD0BAD0;
        master_tready = 1'b1;
        reset         = 1'b0;
        #1;
        chk("mrst_level", level, 0);
        chk("mrst_tvalid", master_tvalid, 0);
        chk("mrst_tready", slave_tready, 1);
        chk("mrst_tlast", master_tlast, 0);
        q.delete();
        rd_cnt = 0;
        @(negedge clk);
        slave_tvalid = 1'b0;
        reset        = 1'b1;
        step(1'b1, 32'hA5A5A5A5, 1'b0, acc);
        #1;
        chk("mrst_first", master_tdata, 32'hA5A5A5A5);
        step(1'b0, '0, 1'b1, acc);

        // Random back-pressure with phase-varying rates so the FIFO fills and drains
        for (int seg = 0; seg < 10; seg++) begin
            pw = $urandom_range(90, 10);
            pr = $urandom_range(90, 10);
            for (int c = 0; c < 1000; c++) begin
                step($urandom_range(99, 0) < pw, $urandom, $urandom_range(99, 0) < pr, acc);
            end
        end
        // Flush what remains
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, '0, 1'b1, acc);
        #1;
        chk("final_empty", master_tvalid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
